stack_op_issuer: RTL and testbench
==================================

Name: stack_op_issuer

Overview:
- Issue-side controller for the hardware operand stack: accepts stack-machine instructions over a valid/ready handshake and drives the stack's push/pop/write interface.
- Reads the stack's registered top-of-stack outputs to compute ALU results.
- Tracks stack depth itself and blocks underflow/overflow.
- Emits popped values to a downstream consumer through an output handshake.

Parameters:
- WORD_W, 35, stack word width (must match the stack).
- SP_W, 11, stack pointer width. Maximum depth is 2^SP_W-1 = 2047.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- ins_valid  in  1  instruction valid
- ins_ready  out  1  instruction accepted when ins_valid&ins_ready at posedge
- ins_op  in  4  opcode
- ins_imm  in  WORD_W  immediate (PUSH value; DROPN count in [SP_W-1:0])
- st__top_0  in  WORD_W  stack top entry (registered, from stack)
- st__top_1  in  WORD_W  entry below top (registered, from stack)
- st__push  out  1  stack push strobe
- st__to_pop  out  SP_W  entries popped this cycle (applied before push)
- st__to_push  out  WORD_W  word written on push
- out_valid  out  1  output word valid
- out_data  out  WORD_W  output word
- out_ready  in  1  consumer accepts when out_valid&out_ready
- err  out  1  sticky error
- depth  out  SP_W+1  current logical stack depth

Behaviour:
- Reset (async): state=IDLE, st__push=0, st__to_pop=0, st__to_push=0, out_valid=0, out_data=0, err=0, depth=0. Reset mid-operation aborts any op; no stack strobes issue after reset deasserts.
- States:
  - IDLE: ins_ready=1.
  - EXEC: one cycle, stack strobes asserted.
  - SETTLE: one cycle, ins_ready=0.
  - EMIT: out_valid=1.
- Stack latency rule: the stack's tops reflect a new sp two edges after the strobe edge. Every stack-modifying op is therefore IDLE->EXEC->SETTLE->IDLE, 3 cycles per op. Tops sampled in IDLE are always valid for the current depth.
- st__push, st__to_pop, st__to_push are registered. They are nonzero only in EXEC and return to 0 the cycle after.
- Opcodes (depth requirement / stack action):
  - 0 NOP: none. Consumed in IDLE, stays IDLE.
  - 1 PUSH: pop 0, push ins_imm.
  - 2 DROP: depth>=1. Pop 1, no push.
  - 3 DUP: depth>=1. Pop 0, push top_0.
  - 4 OVER: depth>=2. Pop 0, push top_1.
  - 5 ADD: depth>=2. Pop 2, push top_1+top_0.
  - 6 SUB: depth>=2. Pop 2, push top_1-top_0.
  - 7 AND, 8 OR, 9 XOR: depth>=2. Pop 2, push top_1 op top_0.
  - A DROPN: n=ins_imm[SP_W-1:0], depth>=n. Pop n, no push. n=0 is a legal no-op that still traverses EXEC/SETTLE.
  - B OUT: depth>=1. IDLE->EMIT, out_data=top_0 (captured at accept). Held stable until out_ready. Then EMIT->EXEC with pop 1, then SETTLE.
  - C-F: illegal.
- Arithmetic: modulo 2^WORD_W. No flags.
- Depth update: depth <= depth - pop + push, applied at the EXEC edge.
- Overflow: an op whose resulting depth exceeds 2047 is rejected (PUSH/DUP/OVER at depth 2047).
- Error handling: on underflow, overflow or illegal opcode, the instruction is still consumed and err is set. No stack strobes and no depth change occur; state stays IDLE. err clears only on reset; later ops proceed normally.
- ins_ready=0 in EXEC, SETTLE and EMIT. An instruction held with ins_valid during those states is not consumed.
- out_valid deasserts on the edge after the out_valid&out_ready handshake.

Test Plan:
- Reset, PUSH 5, PUSH 7, ADD, OUT with out_ready=1 -> out_data=12 (0x00000000C). Stack sees push at depth 1,2, then to_pop=2/push 12, then to_pop=1. Final depth=0, err=0.
- PUSH 3, PUSH 10, SUB, OUT -> out_data=0x7FFFFFFF9 (-7 mod 2^35). Each push/sub op occupies exactly 3 cycles with ins_valid held high.
- OUT with out_ready=0 for 5 cycles, then 1 -> out_valid high 6 cycles, out_data stable. Single to_pop=1 strobe after the handshake; ins_ready=0 throughout.
- At depth 0: DROP, then ADD, then opcode 0xE -> err=1 after the first; no st__push or nonzero st__to_pop ever; depth stays 0. A subsequent PUSH 1 executes normally.
- PUSH 2047 times, then DUP -> DUP rejected, err=1, depth=2047. Then DROPN 2047 -> st__to_pop=2047 for one cycle, depth=0.
- Assert rst_b low during EXEC of an ADD -> all outputs return to reset values immediately. After release, IDLE with ins_ready=1 and depth=0.

Source files
------------

// File: rtl/stack_op_issuer.sv
// Issue-side controller for the hardware operand stack: decodes stack-machine
// instructions, drives the stack's pop/push strobes and emits popped words downstream.
module stack_op_issuer #(
   parameter int WORD_W = 35,
   parameter int SP_W   = 11
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              ins_valid,
   output logic              ins_ready,
   input  logic [3:0]        ins_op,
   input  logic [WORD_W-1:0] ins_imm,
   input  logic [WORD_W-1:0] st__top_0,
   input  logic [WORD_W-1:0] st__top_1,
   output logic              st__push,
   output logic [SP_W-1:0]   st__to_pop,
   output logic [WORD_W-1:0] st__to_push,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   input  logic              out_ready,
   output logic              err,
   output logic [SP_W:0]     depth
);

   localparam logic [SP_W:0] MAX_DEPTH = {1'b0, {SP_W{1'b1}}};

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_PUSH  = 4'h1;
   localparam logic [3:0] OP_DROP  = 4'h2;
   localparam logic [3:0] OP_DUP   = 4'h3;
   localparam logic [3:0] OP_OVER  = 4'h4;
   localparam logic [3:0] OP_ADD   = 4'h5;
   localparam logic [3:0] OP_SUB   = 4'h6;
   localparam logic [3:0] OP_AND   = 4'h7;
   localparam logic [3:0] OP_OR    = 4'h8;
   localparam logic [3:0] OP_XOR   = 4'h9;
   localparam logic [3:0] OP_DROPN = 4'hA;
   localparam logic [3:0] OP_OUT   = 4'hB;

   typedef enum logic [1:0] {IDLE, EXEC, SETTLE, EMIT} state_e;

   state_e              state_q, state_d;
   logic                push_q, push_d;
   logic [SP_W-1:0]     to_pop_q, to_pop_d;
   logic [WORD_W-1:0]   to_push_q, to_push_d;
   logic                out_valid_q, out_valid_d;
   logic [WORD_W-1:0]   out_data_q, out_data_d;
   logic                err_q, err_d;
   logic [SP_W:0]       depth_q, depth_d;

   logic [SP_W:0]       need_depth;
   logic [SP_W-1:0]     pop_n;
   logic                do_push;
   logic [WORD_W-1:0]   push_val;
   logic                op_legal;
   logic                underflow;
   logic                overflow;
   logic                reject;

   // Decode: tops are trustworthy whenever the FSM sits in IDLE.
   always_comb begin
      need_depth = '0;
      pop_n      = '0;
      do_push    = 1'b0;
      push_val   = '0;
      op_legal   = 1'b1;
      case (ins_op)
         OP_NOP: ;
         OP_PUSH: begin
            do_push  = 1'b1;
            push_val = ins_imm;
         end
         OP_DROP: begin
            need_depth = (SP_W+1)'(1);
            pop_n      = SP_W'(1);
         end
         OP_DUP: begin
            need_depth = (SP_W+1)'(1);
            do_push    = 1'b1;
            push_val   = st__top_0;
         end
         OP_OVER: begin
            need_depth = (SP_W+1)'(2);
            do_push    = 1'b1;
            push_val   = st__top_1;
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            need_depth = (SP_W+1)'(2);
            pop_n      = SP_W'(2);
            do_push    = 1'b1;
            case (ins_op)
               OP_ADD:  push_val = st__top_1 + st__top_0;
               OP_SUB:  push_val = st__top_1 - st__top_0;
               OP_AND:  push_val = st__top_1 & st__top_0;
               OP_OR:   push_val = st__top_1 | st__top_0;
               default: push_val = st__top_1 ^ st__top_0;
            endcase
         end
         OP_DROPN: begin
            pop_n      = ins_imm[SP_W-1:0];
            need_depth = {1'b0, ins_imm[SP_W-1:0]};
         end
         OP_OUT: need_depth = (SP_W+1)'(1);
         default: op_legal = 1'b0;
      endcase
   end

   // Only pure pushes can grow the stack; binary ops pop two before pushing one.
   assign underflow = (depth_q < need_depth);
   assign overflow  = do_push && (pop_n == '0) && (depth_q == MAX_DEPTH);
   assign reject    = !op_legal || underflow || overflow;

   always_comb begin
      state_d     = state_q;
      push_d      = 1'b0;
      to_pop_d    = '0;
      to_push_d   = '0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      err_d       = err_q;
      depth_d     = depth_q;
      ins_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            ins_ready = 1'b1;
            if (ins_valid) begin
               if (reject) begin
                  err_d = 1'b1;
               end else if (ins_op == OP_OUT) begin
                  state_d     = EMIT;
                  out_valid_d = 1'b1;
                  out_data_d  = st__top_0;
               end else if (ins_op != OP_NOP) begin
                  state_d   = EXEC;
                  push_d    = do_push;
                  to_pop_d  = pop_n;
                  to_push_d = push_val;
               end
            end
         end
         EXEC: begin
            depth_d = depth_q - {1'b0, to_pop_q} + {{SP_W{1'b0}}, push_q};
            state_d = SETTLE;
         end
         SETTLE: state_d = IDLE;
         EMIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               to_pop_d    = SP_W'(1);
               state_d     = EXEC;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         push_q      <= 1'b0;
         to_pop_q    <= '0;
         to_push_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
         depth_q     <= '0;
      end else begin
         state_q     <= state_d;
         push_q      <= push_d;
         to_pop_q    <= to_pop_d;
         to_push_q   <= to_push_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
         depth_q     <= depth_d;
      end
   end

   assign st__push    = push_q;
   assign st__to_pop  = to_pop_q;
   assign st__to_push = to_push_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign err         = err_q;
   assign depth       = depth_q;

   a_strobe_in_exec: assert property (@(posedge clk) disable iff (!rst_b)
      (push_q || (to_pop_q != '0)) |-> (state_q == EXEC));
   a_depth_bound: assert property (@(posedge clk) disable iff (!rst_b)
      depth_q <= MAX_DEPTH);

endmodule

// File: tb/tb_stack_op_issuer.sv
// Bench for stack_op_issuer: a latency-accurate stack model feeds the tops back,
// and a queue-based reference model predicts strobes, outputs, depth and err.
module tb_stack_op_issuer;
   localparam int WORD_W = 35;
   localparam int SP_W   = 11;
   localparam int MAXD   = 2047;

   typedef logic [WORD_W-1:0] word_t;
   typedef struct {
      bit    push;
      int    pop;
      word_t val;
   } strb_t;

   logic            clk = 1'b0;
   logic            rst_b = 1'b0;
   logic            ins_valid = 1'b0;
   logic            ins_ready;
   logic [3:0]      ins_op = 4'h0;
   word_t           ins_imm = '0;
   word_t           st__top_0, st__top_1;
   logic            st__push;
   logic [SP_W-1:0] st__to_pop;
   word_t           st__to_push;
   logic            out_valid;
   word_t           out_data;
   logic            out_ready = 1'b1;
   logic            err;
   logic [SP_W:0]   depth;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stack_op_issuer #(.WORD_W(WORD_W), .SP_W(SP_W)) dut (
      .clk(clk), .rst_b(rst_b),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op), .ins_imm(ins_imm),
      .st__top_0(st__top_0), .st__top_1(st__top_1),
      .st__push(st__push), .st__to_pop(st__to_pop), .st__to_push(st__to_push),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .err(err), .depth(depth)
   );

   // Stack: sp/memory update one edge after the strobe edge, tops one edge later.
   word_t smem [0:MAXD];
   int    ssp;
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ssp       <= 0;
         st__top_0 <= '0;
         st__top_1 <= '0;
      end else begin
         int nsp;
         nsp = ssp - int'(st__to_pop);
         if (nsp < 0) nsp = 0;
         if (nsp > MAXD) nsp = MAXD;
         if (st__push) smem[nsp] <= st__to_push;
         ssp       <= nsp + (st__push ? 1 : 0);
         st__top_0 <= (ssp >= 1) ? smem[ssp-1] : '0;
         st__top_1 <= (ssp >= 2) ? smem[ssp-2] : '0;
      end
   end

   // Reference model state
   word_t mq[$];
   strb_t exp_strb[$];
   word_t exp_out[$];
   bit    m_err = 1'b0;
   int    pending = 0;
   int    stall_left = 0;
   int    n_strb = 0;
   int    last_pop = 0;
   int    emit_len = 0;
   int    last_emit_len = 0;
   word_t last_out = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic stack_op(input int pop, input bit push, input word_t val);
      strb_t s;
      for (int i = 0; i < pop; i++) void'(mq.pop_back());
      if (push) mq.push_back(val);
      if (pop > 0 || push) begin
         s.push = push;
         s.pop  = pop;
         s.val  = push ? val : '0;
         exp_strb.push_back(s);
      end
      pending = 2;
   endtask

   task automatic model_accept(input logic [3:0] op, input word_t imm, input int k);
      int    d;
      int    n;
      word_t t0, t1;
      d  = mq.size();
      t0 = '0;
      t1 = '0;
      if (d >= 1) t0 = mq[d-1];
      if (d >= 2) t1 = mq[d-2];
      n = int'(imm[SP_W-1:0]);
      pending = 0;
      case (op)
         4'h0: ;
         4'h1: if (d >= MAXD) m_err = 1'b1; else stack_op(0, 1'b1, imm);
         4'h2: if (d < 1) m_err = 1'b1; else stack_op(1, 1'b0, '0);
         4'h3: if (d < 1 || d >= MAXD) m_err = 1'b1; else stack_op(0, 1'b1, t0);
         4'h4: if (d < 2 || d >= MAXD) m_err = 1'b1; else stack_op(0, 1'b1, t1);
         4'h5: if (d < 2) m_err = 1'b1; else stack_op(2, 1'b1, t1 + t0);
         4'h6: if (d < 2) m_err = 1'b1; else stack_op(2, 1'b1, t1 - t0);
         4'h7: if (d < 2) m_err = 1'b1; else stack_op(2, 1'b1, t1 & t0);
         4'h8: if (d < 2) m_err = 1'b1; else stack_op(2, 1'b1, t1 | t0);
         4'h9: if (d < 2) m_err = 1'b1; else stack_op(2, 1'b1, t1 ^ t0);
         4'hA: if (n > d) m_err = 1'b1; else stack_op(n, 1'b0, '0);
         4'hB: if (d < 1) m_err = 1'b1;
               else begin
                  exp_out.push_back(t0);
                  stack_op(1, 1'b0, '0);
                  pending    = k + 3;
                  stall_left = k;
               end
         default: m_err = 1'b1;
      endcase
   endtask

   task automatic service_stall();
      if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else begin
         out_ready = 1'b1;
      end
   endtask

   task automatic tick_idle();
      @(negedge clk);
      ins_valid = 1'b0;
      service_stall();
      @(posedge clk);
      if (pending > 0) pending--;
   endtask

   task automatic drain(input int n);
      repeat (n) tick_idle();
      #3;
   endtask

   // Offer one instruction; k = cycles the consumer stalls if it is an OUT.
   task automatic issue(input logic [3:0] op, input word_t imm, input int k, input int gap);
      int waits;
      int exp_wait;
      for (int g = 0; g < gap; g++) tick_idle();
      exp_wait = pending;
      @(negedge clk);
      service_stall();
      ins_valid = 1'b1;
      ins_op    = op;
      ins_imm   = imm;
      waits     = 0;
      while (!ins_ready) begin
         @(posedge clk);
         waits++;
         if (waits > 300) begin
            bad++;
            total++;
            $display("FAIL ins_accept_timeout: waited %0d cycles, want %0d", waits, exp_wait);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "instruction never accepted");
         end
         @(negedge clk);
         service_stall();
      end
      @(posedge clk);
      model_accept(op, imm, k);
      check("ins_wait", 64'(waits), 64'(exp_wait));
      #1 ins_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_b     = 1'b0;
      ins_valid = 1'b0;
      out_ready = 1'b1;
      mq.delete();
      exp_strb.delete();
      exp_out.delete();
      m_err      = 1'b0;
      pending    = 0;
      stall_left = 0;
      emit_len   = 0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
   endtask

   function automatic word_t rand_word();
      return word_t'({$urandom(), $urandom()});
   endfunction

   // Per-cycle comparison against the model
   always begin
      @(negedge clk);
      #1;
      if (rst_b) begin
         if (st__push || st__to_pop != '0) begin
            n_strb++;
            last_pop = int'(st__to_pop);
            check("strobe_ready_low", 64'(ins_ready), 64'(0));
            if (exp_strb.size() == 0) begin
               check("unexpected_strobe", 64'(st__to_pop), 64'(0));
            end else begin
               strb_t e;
               e = exp_strb.pop_front();
               check("st_push", 64'(st__push), 64'(e.push));
               check("st_to_pop", 64'(st__to_pop), 64'(e.pop));
               check("st_to_push", 64'(st__to_push), 64'(e.val));
            end
         end else begin
            check("st_to_push_idle", 64'(st__to_push), 64'(0));
         end
         if (out_valid) begin
            emit_len++;
            check("emit_ready_low", 64'(ins_ready), 64'(0));
            if (exp_out.size() == 0) begin
               check("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
               check("out_data", 64'(out_data), 64'(exp_out[0]));
               if (out_ready) begin
                  last_out      = out_data;
                  last_emit_len = emit_len;
                  emit_len      = 0;
                  void'(exp_out.pop_front());
               end
            end
         end
         if (ins_ready) begin
            check("depth", 64'(depth), 64'(mq.size()));
            check("err", 64'(err), 64'(m_err));
         end
      end
   end

   initial begin
      #1_000_000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      #3;
      check("rst_push", 64'(st__push), 64'(0));
      check("rst_to_pop", 64'(st__to_pop), 64'(0));
      check("rst_to_push", 64'(st__to_push), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_depth", 64'(depth), 64'(0));
      check("rst_ins_ready", 64'(ins_ready), 64'(1));
      repeat (2) @(negedge clk);
      rst_b = 1'b1;

      // 5 + 7 = 12, emitted through OUT
      base = n_strb;
      issue(4'h1, word_t'(5), 0, 0);
      issue(4'h1, word_t'(7), 0, 0);
      issue(4'h5, '0, 0, 0);
      issue(4'hB, '0, 0, 0);
      drain(6);
      check("add_out", 64'(last_out), 64'h00000000C);
      check("add_strobes", 64'(n_strb - base), 64'(4));
      check("add_depth", 64'(depth), 64'(0));
      check("add_err", 64'(err), 64'(0));

      // 3 - 10 wraps modulo 2^35
      issue(4'h1, word_t'(3), 0, 0);
      issue(4'h1, word_t'(10), 0, 0);
      issue(4'h6, '0, 0, 0);
      issue(4'hB, '0, 0, 0);
      drain(6);
      check("sub_out", 64'(last_out), 64'h7FFFFFFF9);

      // Consumer stalls 5 cycles
      base = n_strb;
      issue(4'h1, word_t'(35'h55), 0, 0);
      issue(4'hB, '0, 5, 0);
      drain(12);
      check("stall_emit_len", 64'(last_emit_len), 64'(6));
      check("stall_out", 64'(last_out), 64'h55);
      check("stall_strobes", 64'(n_strb - base), 64'(2));

      // Underflow and illegal opcode at depth 0
      base = n_strb;
      issue(4'h2, '0, 0, 0);
      drain(1);
      check("uf_err_first", 64'(err), 64'(1));
      issue(4'h5, '0, 0, 0);
      issue(4'hE, '0, 0, 0);
      drain(3);
      check("uf_depth", 64'(depth), 64'(0));
      check("uf_no_strobe", 64'(n_strb - base), 64'(0));
      issue(4'h1, word_t'(1), 0, 0);
      drain(4);
      check("uf_push_depth", 64'(depth), 64'(1));
      check("uf_push_strobe", 64'(n_strb - base), 64'(1));

      // Fill to 2047, overflow a DUP, then DROPN everything
      do_reset();
      for (int i = 0; i < MAXD; i++) issue(4'h1, rand_word(), 0, 0);
      drain(3);
      check("full_depth", 64'(depth), 64'(2047));
      check("full_err", 64'(err), 64'(0));
      issue(4'h3, '0, 0, 0);
      drain(3);
      check("ovf_err", 64'(err), 64'(1));
      check("ovf_depth", 64'(depth), 64'(2047));
      issue(4'hA, word_t'(2047), 0, 0);
      drain(4);
      check("dropn_pop", 64'(last_pop), 64'(2047));
      check("dropn_depth", 64'(depth), 64'(0));

      // Reset asserted during EXEC of an ADD
      do_reset();
      issue(4'h1, word_t'(1), 0, 0);
      issue(4'h1, word_t'(2), 0, 0);
      issue(4'h5, '0, 0, 0);
      @(negedge clk);
      #2;
      rst_b = 1'b0;
      #1;
      check("mid_rst_push", 64'(st__push), 64'(0));
      check("mid_rst_to_pop", 64'(st__to_pop), 64'(0));
      check("mid_rst_to_push", 64'(st__to_push), 64'(0));
      check("mid_rst_out_valid", 64'(out_valid), 64'(0));
      check("mid_rst_depth", 64'(depth), 64'(0));
      check("mid_rst_err", 64'(err), 64'(0));
      do_reset();
      @(posedge clk);
      #3;
      check("post_rst_ready", 64'(ins_ready), 64'(1));
      check("post_rst_depth", 64'(depth), 64'(0));
      drain(4);

      // Randomized traffic, two rounds so err is meaningful in each
      for (int round = 0; round < 2; round++) begin
         do_reset();
         for (int i = 0; i < 300; i++) begin
            int    r;
            int    k;
            int    gap;
            logic [3:0] op;
            word_t imm;
            r   = $urandom_range(0, 99);
            imm = rand_word();
            if (r < 35)      op = 4'h1;
            else if (r < 40) op = 4'h0;
            else if (r < 45) op = 4'h2;
            else if (r < 52) op = 4'h3;
            else if (r < 58) op = 4'h4;
            else if (r < 83) op = 4'(5 + $urandom_range(0, 4));
            else if (r < 87) begin
               int n;
               op = 4'hA;
               n  = $urandom_range(0, mq.size() + 1);
               imm[SP_W-1:0] = n[SP_W-1:0];
            end
            else if (r < 98) op = 4'hB;
            else             op = 4'(12 + $urandom_range(0, 3));
            k   = $urandom_range(0, 3);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            issue(op, imm, k, gap);
         end
         drain(12);
         check("rand_strb_drained", 64'(exp_strb.size()), 64'(0));
         check("rand_out_drained", 64'(exp_out.size()), 64'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
